// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - register file with per-register scoreboard busy bits
// Combinational tri-state read ports, one write port, one reserve port.
module register_file_sb #(
  parameter int WORD_SIZE = 32,
  parameter int SEL_WIDTH = 4,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 oe_a,
  input  logic                 oe_b,
  input  logic [SEL_WIDTH-1:0] sel_a,
  input  logic [SEL_WIDTH-1:0] sel_b,
  input  logic                 ld,
  input  logic [SEL_WIDTH-1:0] sel_w,
  input  logic [WORD_SIZE-1:0] input_bus,
  input  logic                 rsv,
  input  logic [SEL_WIDTH-1:0] sel_r,
  output tri   [WORD_SIZE-1:0] a_bus,
  output tri   [WORD_SIZE-1:0] b_bus,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 rsv_err
);

  localparam int DEPTH = 1 << SEL_WIDTH;

  logic [WORD_SIZE-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]     busy_q;
  logic [DEPTH-1:0]     busy_d;
  logic                 rsv_err_q;
  logic                 rsv_err_d;

  logic                 ld_ok;
  logic                 rsv_ok;
  logic [WORD_SIZE-1:0] rd_a;
  logic [WORD_SIZE-1:0] rd_b;

  // Strobes are dead during reset and for a hardwired-zero index 0.
  assign ld_ok  = ld  && rst_n && !((ZERO_REG != 0) && (sel_w == '0));
  assign rsv_ok = rsv && rst_n && !((ZERO_REG != 0) && (sel_r == '0));

  always_comb begin
    busy_d = busy_q;
    if (ld_ok) busy_d[sel_w] = 1'b0;
    if (rsv_ok) busy_d[sel_r] = 1'b1;
    rsv_err_d = rsv_ok && busy_q[sel_r] && !(ld_ok && (sel_w == sel_r));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      if (ld_ok) regs_q[sel_w] <= input_bus;
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  always_comb begin
    rd_a   = regs_q[sel_a];
    busy_a = busy_q[sel_a];
    if ((BYPASS != 0) && ld_ok && (sel_w == sel_a)) begin
      rd_a   = input_bus;
      busy_a = rsv_ok && (sel_r == sel_a);
    end
    if ((ZERO_REG != 0) && (sel_a == '0)) begin
      rd_a   = '0;
      busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_b   = regs_q[sel_b];
    busy_b = busy_q[sel_b];
    if ((BYPASS != 0) && ld_ok && (sel_w == sel_b)) begin
      rd_b   = input_bus;
      busy_b = rsv_ok && (sel_r == sel_b);
    end
    if ((ZERO_REG != 0) && (sel_b == '0)) begin
      rd_b   = '0;
      busy_b = 1'b0;
    end
  end

  assign a_bus   = oe_a ? rd_a : {WORD_SIZE{1'bz}};
  assign b_bus   = oe_b ? rd_b : {WORD_SIZE{1'bz}};
  assign rsv_err = rsv_err_q;

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 Parameter SEL_WIDTH, default 4, register select width; depth is exactly 2**SEL_WIDTH registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes and reservations.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to the read ports.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 oe_a, oe_b  input  1 each  output enables for a_bus and b_bus.
REQ-008 sel_a, sel_b  input  SEL_WIDTH each  read selects for a_bus and b_bus.
REQ-009 ld  input  1  write strobe.
REQ-010 sel_w  input  SEL_WIDTH  write select (independent of read selects).
REQ-011 input_bus  input  WORD_SIZE  write data.
REQ-012 rsv  input  1  reserve strobe: marks register sel_r as pending a future write.
REQ-013 sel_r  input  SEL_WIDTH  reserve select.
REQ-014 a_bus, b_bus  output tri  WORD_SIZE each  read data; high-Z when the matching oe is 0.
REQ-015 busy_a, busy_b  output  1 each  scoreboard busy bit of the register on sel_a / sel_b (combinational, independent of oe).
REQ-016 rsv_err  output  1  registered one-cycle pulse flagging an illegal reservation.

Function
REQ-017 Storage is 2**SEL_WIDTH words; every index 0..2**SEL_WIDTH-1 is readable and writable.
REQ-018 On a rising edge with ld=1, register[sel_w] takes input_bus; write latency one cycle.
REQ-019 Reads are combinational: a_bus = register[sel_a] when oe_a=1, else all Z; likewise b_bus.
REQ-020 With BYPASS=1, ld=1 and sel_a==sel_w, a_bus presents input_bus in the same cycle; likewise b_bus.
REQ-021 With BYPASS=0, reads return the pre-edge stored value during a write cycle.
REQ-022 A per-register busy bit exists; rsv=1 sets busy[sel_r] on the edge.
REQ-023 ld=1 clears busy[sel_w] on the edge, whether or not it was set.
REQ-024 rsv=1 and ld=1 on the same register in the same cycle: the write lands and busy ends set (new reservation wins).
REQ-025 rsv=1 and ld=1 on different registers: both take effect independently.
REQ-026 busy_a/busy_b reflect the stored busy bit; with BYPASS=1 a same-cycle ld to that index forces the flag to 0 unless REQ-024 applies to it.
REQ-027 rsv=1 to a register already busy and not cleared the same cycle: busy stays set and rsv_err=1 for the next cycle only.
REQ-028 ZERO_REG=1: index 0 always reads 0, busy[0] is always 0, ld/rsv to index 0 are ignored, and rsv to index 0 raises no rsv_err.
REQ-029 rsv_err is 0 in every cycle not following an illegal reservation.

Reset
REQ-030 rst_n=0 asynchronously clears all registers to 0, all busy bits to 0 and rsv_err to 0, independent of clk.
REQ-031 While rst_n=0, ld and rsv are ignored; a/b_bus still follow oe (drive 0 or Z).
REQ-032 The first edge after rst_n rises behaves normally; writes or reservations pending at reset are discarded.

Verification
REQ-033 Reset, oe_a=1, sel_a=5 -> a_bus=0x00000000, busy_a=0; oe_a=0 -> a_bus all Z.
REQ-034 ld=1, sel_w=15, input_bus=0xDEADBEEF; next cycle sel_b=15, oe_b=1 -> b_bus=0xDEADBEEF (checks top index exists).
REQ-035 BYPASS=1: ld=1, sel_w=3, input_bus=0x12345678, sel_a=3, oe_a=1 in the same cycle -> a_bus=0x12345678 before the edge.
REQ-036 rsv, sel_r=7 -> busy_a=1 (sel_a=7); second rsv on 7 -> rsv_err=1 one cycle; ld sel_w=7 -> busy_a=0.
REQ-037 rsv and ld both on 9 in one cycle, data 0xA5A5A5A5 -> register 9=0xA5A5A5A5, busy[9]=1, rsv_err=0.
REQ-038 ZERO_REG=1: ld sel_w=0 data 0xFFFFFFFF and rsv sel_r=0 -> a_bus(sel_a=0)=0, busy_a=0, rsv_err=0; rst_n pulsed low mid-cycle after writes -> all reads 0 immediately.
